reg_bank_arbiter: RTL and testbench
===================================

# reg_bank_arbiter

- Owns a bank of NREGS 16-bit registers with synchronous clear.
- Shares the bank between two requesters (port 0, port 1) through round-robin arbitration: one read or write per cycle.
- Provides a hardware clear sequence that zeroes every register, one per cycle.
- Sits between the control unit (port 0) and the debug/load path (port 1) as the single owner of general-purpose register storage.

## Interface
Parameters:
- NREGS, 8, number of registers; power of two, 2..16.
- DW, 16, register width.
- AW, $clog2(NREGS), address width; derived, not overridden.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RES  in  1  reset; asynchronous assert, active-low.
- REQ0 / REQ1  in  1  access request, held high until granted.
- WE0 / WE1  in  1  1 = write, 0 = read; stable while REQ high.
- ADDR0 / ADDR1  in  AW  register index; stable while REQ high.
- WDATA0 / WDATA1  in  DW  write data; stable while REQ high.
- GNT0 / GNT1  out  1  combinational; one-cycle grant; access executes on the edge ending that cycle.
- RDATA  out  DW  registered read data.
- RVALID  out  1  registered; one-cycle pulse, RDATA valid.
- RID  out  1  requester that owns the current RDATA.
- CLR  in  1  level-sampled clear command.
- BUSY  out  1  registered; high during the clear sweep.

## Operation
FSM states:
- IDLE:
  - CLR=1 → CLEAR; counter ← 0; no grant this cycle, even with REQ pending.
  - Otherwise arbitrate.
- CLEAR:
  - Each cycle writes 0 to register[counter], then counter+1.
  - After index NREGS-1 is written → IDLE.
  - REQ ignored; GNT0 = GNT1 = 0; CLR ignored.

Arbitration (IDLE, CLR=0):
- Single request → that port granted.
- Both requesting → port named by priority pointer PTR granted.
- After any grant, PTR ← index of the port not granted.
- At most one GNT high per cycle.
- No request → no grant, PTR unchanged.

Access rules:
- Write: register[ADDR] ← WDATA at the granting edge.
- Read: RDATA ← register[ADDR] at the granting edge (pre-write value of that edge); RVALID=1; RID=granted port.
- RVALID clears the next cycle unless a new read is granted.
- RDATA holds its last value when RVALID=0.

Reset (RES=0), immediate and asynchronous:
- All registers = 0; state = IDLE; counter = 0; PTR = 0.
- RDATA = 0, RVALID = 0, RID = 0, BUSY = 0.
- GNT0/GNT1 forced 0 while RES=0.
- Reset during CLEAR abandons the sweep; all registers are zeroed anyway.

## Timing
- Grant latency: 0 cycles after REQ when the bank is free.
- Worst-case wait under continuous contention: 1 cycle.
- Read latency: RVALID rises 1 cycle after the GNT cycle.
- Write visibility: a read granted the cycle after a write sees the new value.
- Clear:
  - CLR sampled in cycle t → BUSY high in t+1 .. t+NREGS.
  - Grants resume in cycle t+NREGS+1 at the earliest.
  - Sweep occupies NREGS+1 cycles including the sampling cycle.
- Requester drops REQ without GNT: allowed; no access occurs.

## Structure
- Shared package reg_bank_pkg:
  - FSM state enum {ST_IDLE, ST_CLEAR}.
  - Default widths (DW=16, NREGS=8).
- Sub-module rr_arb2:
  - Inputs: req[1:0], enable, CLK, RES.
  - Outputs: gnt[1:0] (one-hot or zero).
  - Holds PTR.
- Top level keeps:
  - Storage array.
  - FSM and clear counter.
  - Read register.

## Test plan
- Reset with all registers preloaded 16'hFFFF, RES=0 → RDATA=0, RVALID=0, BUSY=0; after release, read of every address returns 16'h0000.
- Port 0 writes 16'hA5A5 to reg 3, next cycle port 1 reads reg 3 → GNT1 in the following cycle, then RDATA=16'hA5A5, RVALID=1, RID=1.
- REQ0 and REQ1 both held for 4 cycles after reset → grants alternate 0,1,0,1; never both high.
- CLR pulsed while REQ0 is high (NREGS=8) → GNT0 stays 0 for 9 cycles, BUSY high 8 cycles; GNT0 fires the cycle after BUSY falls; all registers read 0.
- RES asserted mid-clear at counter=4 → BUSY=0 immediately; state IDLE after release; a write to reg 7 succeeds with no residual sweep.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// ---------------------------------------------------------------------------
// reg_bank_pkg
// Shared definitions for the general-purpose register bank and its arbiter.
//   state_t        : bank controller state (normal service / clear sweep)
//   port_t         : requester identity, also the encoding of RID
//   DEF_NREGS/DW   : default bank geometry
// ---------------------------------------------------------------------------
package reg_bank_pkg;

    localparam int DEF_NREGS = 8;
    localparam int DEF_DW    = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    typedef enum logic {
        PORT_CTRL  = 1'b0,   // control unit
        PORT_DEBUG = 1'b1    // debug / load path
    } port_t;

endpackage : reg_bank_pkg

// File: rtl/reg_bank_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter with a single priority pointer.
// Ports:
//   CLK    in   clock
//   RES    in   asynchronous active-low reset; forces gnt to zero while low
//   req    in   [1:0] request vector
//   enable in   arbitration allowed this cycle
//   gnt    out  [1:0] combinational grant, one-hot or zero
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic       CLK,
    input  logic       RES,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    // Index of the port that wins when both request.
    logic ptr_q;

    // NOTE: every signal written in an always_comb gets a default on entry,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        gnt = 2'b00;
        if (enable && RES) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // The port just served loses priority; an idle cycle leaves it alone.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            ptr_q <= 1'b0;
        end else if (gnt[0]) begin
            ptr_q <= 1'b1;
        end else if (gnt[1]) begin
            ptr_q <= 1'b0;
        end
    end

endmodule : rr_arb2

// File: rtl/reg_bank_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bank_arbiter
// Single owner of the general-purpose register bank. Two requesters share
// one access per cycle through a round-robin arbiter; a clear command
// sweeps the bank to zero, one register per cycle.
// Ports:
//   CLK             in   clock, all state changes on the rising edge
//   RES             in   asynchronous active-low reset
//   REQ0/REQ1       in   access request, held until granted
//   WE0/WE1         in   1 = write, 0 = read
//   ADDR0/ADDR1     in   register index
//   WDATA0/WDATA1   in   write data
//   GNT0/GNT1       out  combinational grant; access happens at the edge
//                        closing the grant cycle
//   RDATA           out  registered read data, held between reads
//   RVALID          out  one-cycle pulse qualifying RDATA
//   RID             out  requester that owns RDATA
//   CLR             in   level-sampled clear command
//   BUSY            out  registered, high while the clear sweep runs
// ---------------------------------------------------------------------------
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter  int NREGS = DEF_NREGS,
    parameter  int DW    = DEF_DW,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WE0,
    input  logic          WE1,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDATA0,
    input  logic [DW-1:0] WDATA1,
    output logic          GNT0,
    output logic          GNT1,
    output logic [DW-1:0] RDATA,
    output logic          RVALID,
    output logic          RID,
    input  logic          CLR,
    output logic          BUSY
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q;

    logic [DW-1:0] regs [NREGS];

    logic [1:0]    gnt;
    logic          arb_en;
    port_t         sel;
    logic          acc_valid;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;

    logic [DW-1:0] rdata_q;
    logic          rvalid_q;
    port_t         rid_q;

    // -----------------------------------------------------------------------
    // Arbitration: only in IDLE, and not in the cycle that samples CLR.
    // -----------------------------------------------------------------------
    assign arb_en = (state_q == ST_IDLE) && !CLR;

    rr_arb2 u_arb (
        .CLK    (CLK),
        .RES    (RES),
        .req    ({REQ1, REQ0}),
        .enable (arb_en),
        .gnt    (gnt)
    );

    assign GNT0 = gnt[0];
    assign GNT1 = gnt[1];

    // Granted port's command, selected once and shared by read and write.
    assign sel       = gnt[1] ? PORT_DEBUG : PORT_CTRL;
    assign acc_valid = |gnt;
    assign acc_we    = (sel == PORT_DEBUG) ? WE1    : WE0;
    assign acc_addr  = (sel == PORT_DEBUG) ? ADDR1  : ADDR0;
    assign acc_wdata = (sel == PORT_DEBUG) ? WDATA1 : WDATA0;

    // -----------------------------------------------------------------------
    // Controller FSM and clear counter
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (CLR) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // Counter wraps to zero after the last index, which is also
                // the value IDLE expects.
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == ST_CLEAR);
        end
    end

    assign BUSY = busy_q;

    // -----------------------------------------------------------------------
    // Register storage
    // -----------------------------------------------------------------------
    // NOTE: the bank must read zero straight out of reset, so the storage is
    // built from resettable flops rather than an inferred RAM macro.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state_q == ST_CLEAR) begin
            regs[cnt_q] <= '0;
        end else if (acc_valid && acc_we) begin
            regs[acc_addr] <= acc_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Read register: captures the pre-edge contents of the addressed entry.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= PORT_CTRL;
        end else begin
            rvalid_q <= acc_valid && !acc_we;
            if (acc_valid && !acc_we) begin
                rdata_q <= regs[acc_addr];
                rid_q   <= sel;
            end
        end
    end

    assign RDATA  = rdata_q;
    assign RVALID = rvalid_q;
    assign RID    = rid_q;

endmodule : reg_bank_arbiter

// File: tb/tb_reg_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_arbiter
// Directed scenarios followed by a randomized run, all checked against a
// transaction-level model of the bank: an array of register values, a
// priority index and a count of remaining clear cycles.
// ---------------------------------------------------------------------------
module tb_reg_bank_arbiter;

    localparam int NREGS = 8;
    localparam int DW    = 16;
    localparam int AW    = $clog2(NREGS);

    logic          CLK = 1'b0;
    logic          RES;
    logic          REQ0, REQ1, WE0, WE1, CLR;
    logic [AW-1:0] ADDR0, ADDR1;
    logic [DW-1:0] WDATA0, WDATA1;
    logic          GNT0, GNT1, RVALID, RID, BUSY;
    logic [DW-1:0] RDATA;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] m_regs [NREGS];
    int            m_ptr;
    int            m_clear_left;
    logic [DW-1:0] m_rdata;
    logic          m_rvalid;
    logic          m_rid;

    // Observations from the most recent step
    logic obs_g0, obs_g1, busy_pre;

    reg_bank_arbiter #(.NREGS(NREGS), .DW(DW)) dut (
        .CLK    (CLK),
        .RES    (RES),
        .REQ0   (REQ0),
        .REQ1   (REQ1),
        .WE0    (WE0),
        .WE1    (WE1),
        .ADDR0  (ADDR0),
        .ADDR1  (ADDR1),
        .WDATA0 (WDATA0),
        .WDATA1 (WDATA1),
        .GNT0   (GNT0),
        .GNT1   (GNT1),
        .RDATA  (RDATA),
        .RVALID (RVALID),
        .RID    (RID),
        .CLR    (CLR),
        .BUSY   (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_ptr        = 0;
        m_clear_left = 0;
        m_rdata      = '0;
        m_rvalid     = 1'b0;
        m_rid        = 1'b0;
    endtask

    task automatic idle_inputs();
        REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0; CLR = 0;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
    endtask

    // One clock cycle. Called at a falling edge with inputs already driven.
    task automatic step();
        logic          e0, e1, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        #1;
        e0 = 0;
        e1 = 0;
        if (m_clear_left == 0 && !CLR) begin
            if (REQ0 && REQ1) begin
                if (m_ptr == 0) e0 = 1; else e1 = 1;
            end else if (REQ0) begin
                e0 = 1;
            end else if (REQ1) begin
                e1 = 1;
            end
        end
        obs_g0   = GNT0;
        obs_g1   = GNT1;
        busy_pre = BUSY;
        check("gnt0", GNT0, e0);
        check("gnt1", GNT1, e1);

        if (e0 || e1) begin
            we   = e1 ? WE1 : WE0;
            addr = e1 ? ADDR1 : ADDR0;
            wd   = e1 ? WDATA1 : WDATA0;
            if (we) begin
                m_regs[addr] = wd;
            end else begin
                m_rdata = m_regs[addr];
                m_rid   = e1;
            end
            m_rvalid = !we;
            m_ptr    = e1 ? 0 : 1;
        end else begin
            m_rvalid = 1'b0;
        end

        if (m_clear_left > 0) begin
            m_clear_left--;
        end else if (CLR) begin
            m_clear_left = NREGS;
            for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        end

        @(posedge CLK);
        @(negedge CLK);
        check("rdata",  RDATA,  m_rdata);
        check("rvalid", RVALID, m_rvalid);
        check("rid",    RID,    m_rid);
        check("busy",   BUSY,   m_clear_left > 0);
    endtask

    // Asserts reset at a falling edge, checks the immediate effect, holds it
    // across one rising edge and releases at the next falling edge.
    task automatic apply_reset();
        RES = 1'b0;
        #1;
        check("rst_rdata",  RDATA,  0);
        check("rst_rvalid", RVALID, 0);
        check("rst_rid",    RID,    0);
        check("rst_busy",   BUSY,   0);
        check("rst_gnt0",   GNT0,   0);
        check("rst_gnt1",   GNT1,   0);
        model_reset();
        @(negedge CLK);
        RES = 1'b1;
    endtask

    initial begin
        int  nog, nbusy;
        logic got;
        logic          p0, p1, pwe0, pwe1;
        logic [AW-1:0] pa0, pa1;
        logic [DW-1:0] pd0, pd1;

        RES = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge CLK);
        RES = 1'b1;

        // ---- Preload all-ones, then reset clears the bank ----
        for (int a = 0; a < NREGS; a++) begin
            REQ0 = 1; WE0 = 1; ADDR0 = AW'(a); WDATA0 = 16'hFFFF;
            step();
        end
        WE0 = 0; ADDR0 = 3'd5;
        step();
        check("preload_rd", RDATA, 16'hFFFF);
        apply_reset();
        idle_inputs();
        for (int a = 0; a < NREGS; a++) begin
            REQ1 = 1; WE1 = 0; ADDR1 = AW'(a);
            step();
            check("post_rst_rd", RDATA, 16'h0000);
        end

        // ---- Write by port 0, read back by port 1 ----
        idle_inputs();
        REQ0 = 1; WE0 = 1; ADDR0 = 3'd3; WDATA0 = 16'hA5A5;
        step();
        REQ0 = 0; REQ1 = 1; WE1 = 0; ADDR1 = 3'd3;
        step();
        check("wr_rd_gnt1",   obs_g1, 1);
        check("wr_rd_rdata",  RDATA,  16'hA5A5);
        check("wr_rd_rvalid", RVALID, 1);
        check("wr_rd_rid",    RID,    1);

        // ---- Continuous contention alternates 0,1,0,1 ----
        apply_reset();
        idle_inputs();
        REQ0 = 1; ADDR0 = 3'd1; REQ1 = 1; ADDR1 = 3'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            check("alt_g0", obs_g0, (i % 2) == 0);
            check("alt_g1", obs_g1, (i % 2) == 1);
        end

        // ---- Clear while port 0 waits ----
        idle_inputs();
        REQ0 = 1; WE0 = 1; ADDR0 = 3'd6; WDATA0 = 16'h1357;
        step();
        WE0 = 0; ADDR0 = 3'd3; CLR = 1;
        nog = 0; nbusy = 0; got = 0;
        step();
        CLR = 0;
        if (!obs_g0) nog++;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (busy_pre) nbusy++;
            if (obs_g0) begin
                got = 1;
                check("gnt_after_busy", busy_pre, 0);
            end else begin
                nog++;
            end
        end
        check("clr_grant_seen", got, 1);
        check("clr_no_gnt_cyc", nog, 9);
        check("clr_busy_cyc",   nbusy, 8);
        idle_inputs();
        for (int a = 0; a < NREGS; a++) begin
            REQ1 = 1; ADDR1 = AW'(a);
            step();
            check("clr_rd_zero", RDATA, 16'h0000);
        end

        // ---- Reset in the middle of a sweep ----
        idle_inputs();
        REQ0 = 1; WE0 = 1; ADDR0 = 3'd7; WDATA0 = 16'h5555;
        step();
        REQ0 = 0; CLR = 1;
        step();
        CLR = 0;
        repeat (4) step();
        check("mid_clr_busy", BUSY, 1);
        apply_reset();
        idle_inputs();
        step();
        REQ0 = 1; WE0 = 1; ADDR0 = 3'd7; WDATA0 = 16'h1234;
        step();
        check("mid_wr_gnt", obs_g0, 1);
        REQ0 = 0; REQ1 = 1; WE1 = 0; ADDR1 = 3'd7;
        step();
        check("mid_rd_val", RDATA, 16'h1234);
        check("mid_no_busy", BUSY, 0);

        // ---- Randomized traffic ----
        idle_inputs();
        p0 = 0; p1 = 0; pwe0 = 0; pwe1 = 0;
        pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!p0 && ($urandom % 3) != 0) begin
                p0 = 1; pwe0 = $urandom % 2;
                pa0 = AW'($urandom_range(NREGS - 1)); pd0 = DW'($urandom);
            end else if (p0 && ($urandom % 16) == 0) begin
                p0 = 0;
            end
            if (!p1 && ($urandom % 3) != 0) begin
                p1 = 1; pwe1 = $urandom % 2;
                pa1 = AW'($urandom_range(NREGS - 1)); pd1 = DW'($urandom);
            end else if (p1 && ($urandom % 16) == 0) begin
                p1 = 0;
            end
            REQ0 = p0; WE0 = pwe0; ADDR0 = pa0; WDATA0 = pd0;
            REQ1 = p1; WE1 = pwe1; ADDR1 = pa1; WDATA1 = pd1;
            CLR  = (($urandom % 60) == 0);
            step();
            if (obs_g0) p0 = 0;
            if (obs_g1) p1 = 0;
        end

        idle_inputs();
        for (int a = 0; a < NREGS; a++) begin
            REQ0 = 1; ADDR0 = AW'(a);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_bank_arbiter
